button_mode_latch: RTL and testbench



---
 rtl/button_mode_latch.sv | 110 +++++++++++
 tb/tb_button_mode_latch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/button_mode_latch.sv
// Input conditioning for the multi-code converter: synchronizes and debounces
// three push-buttons and four slide switches, latching a one-hot-low mode code.
module button_mode_latch #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_WIDTH = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] KEY,
    input  logic [3:0] SW,
    output logic [2:0] B,
    output logic [3:0] S,
    output logic       mode_change
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DB_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0]           key_s1, key_s2;
    logic [3:0]           sw_s1, sw_s2;
    logic [2:0]           kst;
    logic [CNT_WIDTH-1:0] kcnt [3];
    logic [CNT_WIDTH-1:0] scnt;
    logic [2:0]           key_flip;
    logic [2:0]           press;
    logic [2:0]           next_b;

    // Keys idle high (released), so their synchronizers reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1 <= '1;
            key_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // flop samples the pre-edge value; a blocking '=' here would collapse
            // the two synchronizer stages into one.
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    // A key accepts its new level on the edge its counter has run out.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no
        // path leaves it unassigned and no latch is inferred.
        key_flip = '0;
        for (int i = 0; i < 3; i++) begin
            key_flip[i] = (key_s2[i] != kst[i]) && (kcnt[i] == CNT_MAX);
        end
        press = key_flip & kst;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kst <= '1;
            // NOTE: kcnt is a small array of flops, not a RAM, so each entry is
            // reset explicitly; a real memory macro would not be reset like this.
            for (int i = 0; i < 3; i++) kcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (key_s2[i] == kst[i]) begin
                    kcnt[i] <= '0;
                end else if (key_flip[i]) begin
                    kst[i]  <= key_s2[i];
                    kcnt[i] <= '0;
                end else begin
                    kcnt[i] <= kcnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Lowest key index wins when several presses land on the same edge.
    always_comb begin
        next_b = B;
        if (press[0])      next_b = 3'b110;
        else if (press[1]) next_b = 3'b101;
        else if (press[2]) next_b = 3'b011;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            B           <= 3'b111;
            mode_change <= 1'b0;
        end else begin
            B           <= next_b;
            mode_change <= (next_b != B);
        end
    end

    // Switches share one counter; the vector present on the loading edge wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            S    <= '0;
            scnt <= '0;
        end else if (sw_s2 == S) begin
            scnt <= '0;
        end else if (scnt == CNT_MAX) begin
            S    <= sw_s2;
            scnt <= '0;
        end else begin
            scnt <= scnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_button_mode_latch.sv
// Directed bench for button_mode_latch with DB_CYCLES=4: expected outputs are
// queued per clock edge as stimulus is applied and compared when that edge arrives.
module tb_button_mode_latch;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] KEY;
    logic [3:0] SW;
    logic [2:0] B;
    logic [3:0] S;
    logic       mode_change;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];

    button_mode_latch #(.DB_CYCLES(DB), .CNT_WIDTH(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .KEY         (KEY),
        .SW          (SW),
        .B           (B),
        .S           (S),
        .mode_change (mode_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed B/S/mc=%b/%h/%b expected %b/%h/%b",
                   tag, obs[7:5], obs[4:1], obs[0], exp[7:5], exp[4:1], exp[0]);
        end
    endtask

    // Queue expectation {b,s,mc} for edges ecnt+from .. ecnt+to (1 = next edge).
    task automatic expect_range(input string tag, input int from, input int to,
                                input logic [2:0] b, input logic [3:0] s, input logic mc);
        for (int c = from; c <= to; c++) begin
            exp_t e;
            e.cyc = ecnt + c;
            e.tag = tag;
            e.exp = {b, s, mc};
            sb.push_back(e);
        end
    endtask

    // Advance one edge, sample #1 later, and retire every expectation due now.
    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == ecnt) begin
                check($sformatf("%s@%0d", sb[i].tag, ecnt), {B, S, mode_change}, sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        reset = 1'b1;
        KEY   = 3'b111;
        SW    = 4'h0;
        #1;
        check("reset_now", {B, S, mode_change}, {3'b111, 4'h0, 1'b0});
        steps(2);
        reset = 1'b0;

        // Idle inputs: nothing moves.
        expect_range("idle", 1, 20, 3'b111, 4'h0, 1'b0);
        steps(20);

        // Single press of key1, held 10 cycles then released.
        KEY = 3'b101;
        expect_range("k1_wait", 1, DB + 1, 3'b111, 4'h0, 1'b0);
        expect_range("k1_set", DB + 2, DB + 2, 3'b101, 4'h0, 1'b1);
        expect_range("k1_hold", DB + 3, 20, 3'b101, 4'h0, 1'b0);
        steps(10);
        KEY = 3'b111;
        steps(10);

        // 3-cycle glitch on key2 is rejected.
        KEY = 3'b011;
        expect_range("k2_glitch", 1, 10, 3'b101, 4'h0, 1'b0);
        steps(3);
        KEY = 3'b111;
        steps(7);

        // Key0 press selects hex.
        KEY = 3'b110;
        expect_range("k0_wait", 1, DB + 1, 3'b101, 4'h0, 1'b0);
        expect_range("k0_set", DB + 2, DB + 2, 3'b110, 4'h0, 1'b1);
        expect_range("k0_hold", DB + 3, 20, 3'b110, 4'h0, 1'b0);
        steps(8);
        KEY = 3'b111;
        steps(12);

        // Re-pressing the current mode's key: no pulse.
        KEY = 3'b110;
        expect_range("k0_again", 1, 20, 3'b110, 4'h0, 1'b0);
        steps(8);
        KEY = 3'b111;
        steps(12);

        // Reset, then all three keys together: key0 wins.
        reset = 1'b1;
        #1;
        check("reset_async1", {B, S, mode_change}, {3'b111, 4'h0, 1'b0});
        step();
        reset = 1'b0;
        KEY = 3'b000;
        expect_range("all_wait", 1, DB + 1, 3'b111, 4'h0, 1'b0);
        expect_range("all_set", DB + 2, DB + 2, 3'b110, 4'h0, 1'b1);
        expect_range("all_hold", DB + 3, 20, 3'b110, 4'h0, 1'b0);
        steps(10);
        KEY = 3'b111;
        steps(10);

        // Switch 0 -> A.
        SW = 4'hA;
        expect_range("sw_wait", 1, DB + 1, 3'b110, 4'h0, 1'b0);
        expect_range("sw_a", DB + 2, 10, 3'b110, 4'hA, 1'b0);
        steps(10);

        // Toggle 5/B every 2 cycles: count runs through the change and loads B;
        // afterwards B matches S so the 5-runs never reach the limit.
        expect_range("tog_wait", 1, DB + 1, 3'b110, 4'hA, 1'b0);
        expect_range("tog_b", DB + 2, 16, 3'b110, 4'hB, 1'b0);
        for (int r = 0; r < 3; r++) begin
            SW = 4'h5;
            steps(2);
            SW = 4'hB;
            steps(2);
        end
        steps(4);

        // One-cycle blip back to A: S holds B.
        SW = 4'hA;
        expect_range("blip", 1, 10, 3'b110, 4'hB, 1'b0);
        step();
        SW = 4'hB;
        steps(9);

        // Key2 held; reset pulse at cycle 4 forces full re-qualification.
        KEY = 3'b011;
        expect_range("pre_rst", 1, 3, 3'b110, 4'hB, 1'b0);
        steps(3);
        reset = 1'b1;
        #1;
        check("reset_async2", {B, S, mode_change}, {3'b111, 4'h0, 1'b0});
        expect_range("in_rst", 1, 1, 3'b111, 4'h0, 1'b0);
        step();
        reset = 1'b0;
        expect_range("k2_wait", 1, DB + 1, 3'b111, 4'h0, 1'b0);
        expect_range("k2_set", DB + 2, DB + 2, 3'b011, 4'hB, 1'b1);
        expect_range("k2_hold", DB + 3, 12, 3'b011, 4'hB, 1'b0);
        steps(8);
        KEY = 3'b111;
        steps(4);

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
